// File: rtl/packet_accum.sv
// packet_accum: sums K consecutive LEN-beat AXI-Stream packets element-wise and streams out the sum packet.
// Rev 1.0 -- wrap/saturate overflow, s_tlast framing check, registered output stage.
`timescale 1ns/1ps
`default_nettype none

module packet_accum #(
  parameter int DW = 8,
  parameter int DD = 64,
  parameter int OW = 16,
  parameter int KW = 8,
  parameter int LW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    s_tdata,
  input  logic             s_tvalid,
  input  logic             s_tlast,
  output logic             s_tready,
  output logic [OW-1:0]    m_tdata,
  output logic             m_tvalid,
  output logic             m_tlast,
  input  logic             m_tready,
  input  logic [KW+LW:0]   config_packet,
  output logic             pkt_err,
  output logic             grp_done
);

  localparam int            c_AW   = (DD > 1) ? $clog2(DD) : 1;
  localparam logic [LW-1:0] c_DD_L = LW'(DD);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          r_state, w_next;
  logic [LW-1:0]   r_bcnt, r_len, r_rd;
  logic [KW-1:0]   r_pcnt, r_k;
  logic            r_sat, r_rd_done;
  logic [OW-1:0]   r_buf [DD];

  logic [LW-1:0]   w_cfg_len_raw, w_cfg_len, w_len;
  logic [KW-1:0]   w_cfg_k_raw, w_cfg_k, w_k;
  logic            w_cfg_sat, w_sat, w_idle, w_acc, w_blast, w_plast, w_out_end;
  logic [c_AW-1:0] w_widx, w_ridx;
  logic [OW:0]     w_sum;
  logic [OW-1:0]   w_wdata;

  assign w_cfg_len_raw = config_packet[LW-1:0];
  assign w_cfg_k_raw   = config_packet[LW +: KW];
  assign w_cfg_sat     = config_packet[KW+LW];
  assign w_cfg_len     = (w_cfg_len_raw == '0 || w_cfg_len_raw > c_DD_L) ? c_DD_L : w_cfg_len_raw;
  assign w_cfg_k       = (w_cfg_k_raw == '0) ? KW'(1) : w_cfg_k_raw;

  // The first beat of a group frames itself with the live config, later beats with the latched copy.
  assign w_idle  = (r_state == S_IDLE);
  assign w_len   = w_idle ? w_cfg_len : r_len;
  assign w_k     = w_idle ? w_cfg_k   : r_k;
  assign w_sat   = w_idle ? w_cfg_sat : r_sat;

  assign w_acc     = s_tvalid & s_tready;
  assign w_blast   = (r_bcnt == w_len - LW'(1));
  assign w_plast   = (r_pcnt == w_k - KW'(1));
  assign w_widx    = r_bcnt[c_AW-1:0];
  assign w_ridx    = r_rd[c_AW-1:0];
  assign w_out_end = m_tvalid & m_tready & m_tlast;
  assign grp_done  = w_out_end;

  assign w_sum = (OW+1)'(r_buf[w_widx]) + (OW+1)'(s_tdata);

  always_comb begin
    w_wdata = w_sum[OW-1:0];
    if (r_pcnt == '0) begin
      w_wdata = OW'(s_tdata);
    end else if (w_sat && w_sum[OW]) begin
      w_wdata = '1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_acc) w_next = (w_blast && w_plast) ? S_DRAIN : S_ACCUM;
      S_ACCUM: if (w_acc && w_blast && w_plast) w_next = S_DRAIN;
      S_DRAIN: if (w_out_end) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bcnt   <= '0;
      r_pcnt   <= '0;
      r_len    <= '0;
      r_k      <= '0;
      r_sat    <= 1'b0;
      s_tready <= 1'b0;
      pkt_err  <= 1'b0;
    end else begin
      s_tready <= (w_next != S_DRAIN);
      pkt_err  <= w_acc && (s_tlast != w_blast);
      if (w_acc) begin
        if (w_idle) begin
          r_len <= w_cfg_len;
          r_k   <= w_cfg_k;
          r_sat <= w_cfg_sat;
        end
        if (w_blast) begin
          r_bcnt <= '0;
          r_pcnt <= w_plast ? '0 : r_pcnt + KW'(1);
        end else begin
          r_bcnt <= r_bcnt + LW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_buf[w_widx] <= w_wdata;
    end
  end

  // Output skid-free register: reload whenever the current beat is empty or being taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_tdata   <= '0;
      m_tvalid  <= 1'b0;
      m_tlast   <= 1'b0;
      r_rd      <= '0;
      r_rd_done <= 1'b0;
    end else begin
      if (r_state == S_DRAIN && (!m_tvalid || m_tready)) begin
        if (!r_rd_done) begin
          m_tdata   <= r_buf[w_ridx];
          m_tvalid  <= 1'b1;
          m_tlast   <= (r_rd == r_len - LW'(1));
          r_rd_done <= (r_rd == r_len - LW'(1));
          r_rd      <= r_rd + LW'(1);
        end else begin
          m_tvalid <= 1'b0;
          m_tlast  <= 1'b0;
        end
      end
      if (w_out_end) begin
        r_rd      <= '0;
        r_rd_done <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_packet_accum.sv
// tb_packet_accum: drives an OW=16 and an OW=8 packet_accum in lockstep and checks both against a sum model.
`timescale 1ns/1ps
`default_nettype none

module tb_packet_accum;
  localparam int DW = 8, DD = 64, KW = 8, LW = 8;

  logic clk = 1'b0, rst = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic s_tvalid = 1'b0, s_tlast = 1'b0, m_tready = 1'b0;
  logic [KW+LW:0] config_packet = '0;

  logic s_tready_a, m_tvalid_a, m_tlast_a, pkt_err_a, grp_done_a;
  logic s_tready_b, m_tvalid_b, m_tlast_b, pkt_err_b, grp_done_b;
  logic [15:0] m_tdata_a;
  logic [7:0]  m_tdata_b;

  packet_accum #(.DW(DW), .DD(DD), .OW(16), .KW(KW), .LW(LW)) u_dut16 (
    .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(s_tready_a), .m_tdata(m_tdata_a), .m_tvalid(m_tvalid_a), .m_tlast(m_tlast_a),
    .m_tready(m_tready), .config_packet(config_packet), .pkt_err(pkt_err_a), .grp_done(grp_done_a));

  packet_accum #(.DW(DW), .DD(DD), .OW(8), .KW(KW), .LW(LW)) u_dut8 (
    .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(s_tready_b), .m_tdata(m_tdata_b), .m_tvalid(m_tvalid_b), .m_tlast(m_tlast_b),
    .m_tready(m_tready), .config_packet(config_packet), .pkt_err(pkt_err_b), .grp_done(grp_done_b));

  always #5 clk = ~clk;

  typedef struct { int d16; int d8; bit last; } exp_t;
  exp_t exp_q[$];
  int   log16[$];
  int   log8[$];
  int   chk_cnt = 0, pass_cnt = 0;
  int   out_cnt = 0, err_pulses = 0, grp_pulses = 0;
  int   rdy_mode = 0;
  bit   exp_err_cur = 1'b0;
  int   pat[8][64];

  task automatic check(input string name, input longint act, input longint exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  initial begin : p_ready
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = ~m_tready;
        default: m_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin : p_mon
    exp_t e;
    bit pend_err = 1'b0, prev_stall = 1'b0, exp_grp;
    logic [15:0] pd16 = '0;
    logic [7:0]  pd8 = '0;
    logic        pl = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_q.delete();
        pend_err   = 1'b0;
        prev_stall = 1'b0;
      end else begin
        exp_grp = 1'b0;
        check("pkt_err", pkt_err_a, pend_err);
        check("pkt_err_ow8", pkt_err_b, pend_err);
        pend_err = s_tvalid && s_tready_a && exp_err_cur;
        if (pkt_err_a) err_pulses++;
        if (grp_done_a) grp_pulses++;
        if (prev_stall) begin
          check("stall_valid", m_tvalid_a, 1);
          check("stall_data", m_tdata_a, pd16);
          check("stall_data_ow8", m_tdata_b, pd8);
          check("stall_last", m_tlast_a, pl);
        end
        if (exp_q.size() == 0) begin
          check("spurious_valid", m_tvalid_a, 0);
          check("spurious_valid_ow8", m_tvalid_b, 0);
        end else if (m_tvalid_a) begin
          check("tready_in_drain", s_tready_a, 0);
          check("tready_in_drain_ow8", s_tready_b, 0);
          check("valid_ow8", m_tvalid_b, 1);
          if (m_tready) begin
            e = exp_q.pop_front();
            check("data", m_tdata_a, e.d16);
            check("data_ow8", m_tdata_b, e.d8);
            check("last", m_tlast_a, e.last);
            check("last_ow8", m_tlast_b, e.last);
            exp_grp = e.last;
            log16.push_back(int'(m_tdata_a));
            log8.push_back(int'(m_tdata_b));
            out_cnt++;
          end
        end
        check("grp_done", grp_done_a, exp_grp);
        check("grp_done_ow8", grp_done_b, exp_grp);
        prev_stall = m_tvalid_a && !m_tready;
        pd16 = m_tdata_a;
        pd8  = m_tdata_b;
        pl   = m_tlast_a;
      end
    end
  end

  task automatic send_beat(input int d, input bit tl, input bit e, input int gap_max);
    int wd;
    repeat ($urandom_range(0, gap_max)) begin
      s_tvalid = 1'b0;
      s_tdata  = 8'($urandom);
      s_tlast  = 1'($urandom);
      @(posedge clk); #1;
    end
    s_tvalid    = 1'b1;
    s_tdata     = 8'(d);
    s_tlast     = tl;
    exp_err_cur = e;
    wd = 0;
    do begin
      @(negedge clk);
      wd++;
    end while (!s_tready_a && wd < 3000);
    if (!s_tready_a) check("tready_timeout", 0, 1);
    @(posedge clk); #1;
    s_tvalid = 1'b0;
  endtask

  // Model: each output beat is the plain sum over packets, then clamped or reduced modulo 2^OW.
  task automatic send_group(input bit sat, input int kr, input int lr, input bit use_pat,
                            input int err_pkt, input int err_beat, input int gap_max);
    int ke, le;
    longint tot[64];
    int din[8][64];
    exp_t e;
    bit tl;
    ke = (kr == 0) ? 1 : kr;
    le = (lr == 0 || lr > DD) ? DD : lr;
    for (int b = 0; b < 64; b++) tot[b] = 0;
    for (int p = 0; p < ke; p++)
      for (int b = 0; b < le; b++) begin
        din[p][b] = use_pat ? pat[p][b] : int'($urandom_range(0, 255));
        tot[b] += din[p][b];
      end
    for (int b = 0; b < le; b++) begin
      e.d16  = sat ? int'((tot[b] > 65535) ? 65535 : tot[b]) : int'(tot[b] % 65536);
      e.d8   = sat ? int'((tot[b] > 255) ? 255 : tot[b]) : int'(tot[b] % 256);
      e.last = (b == le - 1);
      exp_q.push_back(e);
    end
    config_packet = {sat, 8'(kr), 8'(lr)};
    for (int p = 0; p < ke; p++)
      for (int b = 0; b < le; b++) begin
        tl = (p == err_pkt) ? (b == err_beat) : (b == le - 1);
        send_beat(din[p][b], tl, tl != (b == le - 1), gap_max);
        if (p == 0 && b == 0) config_packet = 17'($urandom);
      end
  endtask

  task automatic wait_drain();
    int wd = 0;
    while (exp_q.size() != 0 && wd < 5000) begin
      @(negedge clk);
      wd++;
    end
    check("drain_timeout", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run_basic();
    int base, g0;
    for (int b = 0; b < 4; b++) begin
      pat[0][b] = b + 1;
      pat[1][b] = 10 * (b + 1);
    end
    base = out_cnt;
    g0   = grp_pulses;
    send_group(1'b0, 2, 4, 1'b1, 99, 0, 0);
    check("latency_edgeN_valid", m_tvalid_a, 0);
    @(posedge clk); #1;
    check("latency_edgeN1_valid", m_tvalid_a, 1);
    repeat (3) @(posedge clk);
    #1;
    check("latency_last_beat", m_tlast_a, 1);
    wait_drain();
    check("basic_sum0", log16[base], 11);
    check("basic_sum1", log16[base + 1], 22);
    check("basic_sum2", log16[base + 2], 33);
    check("basic_sum3", log16[base + 3], 44);
    check("basic_sum3_ow8", log8[base + 3], 44);
    check("basic_grp_pulses", grp_pulses - g0, 1);
  endtask

  initial begin : p_main
    int base, e0, wd;
    #12;
    check("rst_tready", s_tready_a, 0);
    check("rst_tvalid", m_tvalid_a, 0);
    check("rst_tlast", m_tlast_a, 0);
    check("rst_tdata", m_tdata_a, 0);
    check("rst_pkt_err", pkt_err_a, 0);
    check("rst_grp_done", grp_done_a, 0);
    check("rst_tvalid_ow8", m_tvalid_b, 0);
    #10 rst = 1'b1;
    check("tready_before_edge", s_tready_a, 0);
    @(posedge clk); #1;
    check("tready_after_edge", s_tready_a, 1);

    run_basic();

    // 200 + 100: clamps to 255 or wraps to 44 at OW=8, exact 300 at OW=16.
    pat[0][0] = 200;
    pat[1][0] = 100;
    base = out_cnt;
    send_group(1'b1, 2, 1, 1'b1, 99, 0, 1);
    wait_drain();
    check("sat_ow8", log8[base], 255);
    check("sat_ow16", log16[base], 300);
    base = out_cnt;
    send_group(1'b0, 2, 1, 1'b1, 99, 0, 1);
    wait_drain();
    check("wrap_ow8", log8[base], 44);
    check("wrap_ow16", log16[base], 300);

    for (int b = 0; b < 64; b++) pat[0][b] = b;
    rdy_mode = 1;
    base = out_cnt;
    send_group(1'b0, 1, 64, 1'b1, 99, 0, 0);
    wait_drain();
    check("ramp_count", out_cnt - base, 64);
    check("ramp_10", log16[base + 10], 10);
    check("ramp_63", log16[base + 63], 63);

    rdy_mode = 0;
    e0 = err_pulses;
    base = out_cnt;
    send_group(1'b0, 3, 4, 1'b0, 1, 2, 1);
    wait_drain();
    check("err_pulse_count", err_pulses - e0, 2);
    check("err_group_beats", out_cnt - base, 4);

    base = out_cnt;
    send_group(1'b0, 0, 0, 1'b0, 99, 0, 0);
    wait_drain();
    check("clamp_len_beats", out_cnt - base, 64);

    rdy_mode = 2;
    for (int i = 0; i < 15; i++) begin
      int kr, lr;
      kr = $urandom_range(0, 7);
      lr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(1, 6));
      send_group(1'($urandom_range(0, 1)), kr, lr, 1'b0, $urandom_range(0, 7),
                 $urandom_range(0, 63), 2);
      wait_drain();
    end

    rdy_mode = 0;
    base = out_cnt;
    send_group(1'b0, 1, 4, 1'b0, 99, 0, 0);
    wd = 0;
    while (out_cnt < base + 2 && wd < 500) begin
      @(negedge clk);
      wd++;
    end
    check("reset_test_reach", out_cnt - base, 2);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("midrst_tvalid", m_tvalid_a, 0);
    check("midrst_tvalid_ow8", m_tvalid_b, 0);
    check("midrst_tlast", m_tlast_a, 0);
    check("midrst_tdata", m_tdata_a, 0);
    check("midrst_tready", s_tready_a, 0);
    @(posedge clk); #3;
    rst = 1'b1;
    check("midrst_tready_hold", s_tready_a, 0);
    @(posedge clk); #1;
    check("midrst_tready_up", s_tready_a, 1);
    repeat (6) @(posedge clk);
    #1;
    check("midrst_no_output", out_cnt - base, 2);
    run_basic();

    repeat (4) @(posedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin : p_watchdog
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, chk_cnt);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/packet_accum.md
Name: packet_accum

Overview:
- AXI-Stream packet accumulator, the parametrised successor to packet_add.
- Sums K consecutive input packets of LEN beats element-wise into an internal accumulation buffer, then streams the LEN-beat sum packet out.
- Output width, maximum depth and overflow mode (wrap or saturate) are configurable.
- Sits between a sample source and downstream DSP/packetiser blocks on the same clock.

Parameters:
- DW, 8, input data width.
- DD, 64, maximum packet length in beats (buffer depth).
- OW, 16, accumulator/output width; must be at least DW.
- KW, 8, width of the K field in config_packet.
- LW, 8, width of the LEN field in config_packet; must be at least $clog2(DD+1).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- s_tdata  in  DW  input sample.
- s_tvalid  in  1  input valid.
- s_tlast  in  1  input end-of-packet marker; checked only, not used for framing.
- s_tready  out  1  input ready.
- m_tdata  out  OW  summed sample.
- m_tvalid  out  1  output valid.
- m_tlast  out  1  last beat of summed packet.
- m_tready  in  1  downstream ready.
- config_packet  in  1+KW+LW  {sat, k, len}; sat=1 saturates, sat=0 wraps.
- pkt_err  out  1  one-cycle pulse on s_tlast/beat-count mismatch.
- grp_done  out  1  one-cycle pulse when the final beat of a sum packet is accepted downstream.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all counters 0; s_tready=0, m_tvalid=0, m_tlast=0, m_tdata=0, pkt_err=0, grp_done=0. Buffer contents need no reset.
- s_tready is 1 in IDLE and ACCUM and 0 in DRAIN. It goes high on the first clk edge after rst releases.
- Config latch: config_packet is sampled on the first accepted beat of a group (IDLE to ACCUM). Changes mid-group are ignored until the next group.
- Config clamping:
  - k=0 is treated as 1.
  - len=0 or len>DD is treated as DD.
- Beat counter bcnt runs 0..len-1 and defines packet boundaries. Packet counter pcnt runs 0..k-1.
- Accumulation on each accepted beat (s_tvalid & s_tready):
  - pcnt=0: buf[bcnt] = zero-extended s_tdata.
  - pcnt>0: buf[bcnt] = buf[bcnt] + s_tdata, as a read-modify-write in the same cycle using a combinational buffer read.
  - Wrap mode: sum modulo 2^OW.
  - Saturate mode: clamp to 2^OW-1.
- Framing check: on the beat where bcnt=len-1, s_tlast must be 1; on any other beat it must be 0. A mismatch pulses pkt_err for one cycle. The beat is still accumulated and framing continues by count.
- States and transitions:
  - IDLE to ACCUM on the first accepted beat.
  - ACCUM to DRAIN on the accepted beat with bcnt=len-1 and pcnt=k-1.
  - DRAIN to IDLE when the beat with m_tlast=1 is accepted downstream (grp_done pulses that cycle).
- DRAIN output:
  - Registered output stage. m_tdata/m_tvalid load buf[rd] when m_tvalid=0 or m_tready=1 and beats remain.
  - First m_tvalid appears one cycle after entering DRAIN.
  - Full throughput: one beat per clk while m_tready=1.
  - m_tdata/m_tlast hold stable while m_tvalid=1 and m_tready=0.
  - m_tlast=1 on read index len-1.
- Latency: last input beat accepted at edge N, first output valid after edge N+1, packet completes after len beats with no backpressure.
- No input is accepted during DRAIN. A new group may start in the cycle after DRAIN returns to IDLE.
- Reset mid-operation: immediate return to the reset state. The partial group is discarded and no output beat is emitted afterwards.
- Simultaneous pkt_err and ACCUM-to-DRAIN: both take effect.

Test Plan:
- OW=16, config {0,2,4}: packets [1,2,3,4], then [10,20,30,40] -> output 11,22,33,44; m_tlast only on 44; grp_done pulses once.
- OW=8, config {1,2,1}: beats 200, then 100 -> output 255. Same stimulus with config {0,2,1} -> output 44 (300 mod 256).
- config {0,1,64} (k=1): 64-beat ramp 0..63 -> identical ramp out. m_tready toggled 1/0 every cycle -> no beat lost or duplicated; data held stable while stalled.
- config {0,3,4}: s_tlast asserted on beat 2 of packet 1 -> pkt_err pulses on beat 2 and on beat 3 (missing tlast). The group still sums 3 packets of 4 beats.
- config k=0 / len=0 -> behaves as k=1 / len=64. Changing config_packet mid-group does not affect the current group.
- rst driven low during DRAIN after 2 of 4 beats -> m_tvalid=0 immediately. The next group after reset produces correct sums with no stale data.
